// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared Reed-Solomon GF(2^6) constants and FSM state type
package rs_pkg;

    localparam int SYM = 6;
    localparam int K   = 7;
    localparam int P   = 2;

    // x^6 + x + 1
    localparam logic [6:0] GF_POLY = 7'b1000011;

    // g(x) = (x + a)(x + a^2) = x^2 + G1*x + G0
    localparam logic [SYM-1:0] G1 = 6'h06;
    localparam logic [SYM-1:0] G0 = 6'h08;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/gf64_mul.sv
// rtl/gf64_mul.sv - combinational GF(2^6) multiplier reduced by GF_POLY
module gf64_mul
    import rs_pkg::*;
(
    input  logic [SYM-1:0] a,
    input  logic [SYM-1:0] b,
    output logic [SYM-1:0] y
);

    logic [SYM-1:0] acc;
    logic [SYM-1:0] term;

    // Shift-and-add: term walks through a*x^i (reduced), accumulated where b[i] is set
    always_comb begin
        acc  = '0;
        term = a;
        for (int i = 0; i < SYM; i++) begin
            if (b[i]) begin
                acc = acc ^ term;
            end
            term = {term[SYM-2:0], 1'b0} ^ (term[SYM-1] ? GF_POLY[SYM-1:0] : '0);
        end
        y = acc;
    end

endmodule

// File: rtl/rs_parity_encoder.sv
// rtl/rs_parity_encoder.sv - systematic RS(9,7) parity encoder over GF(2^6)
module rs_parity_encoder
    import rs_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   start,
    input  logic [K*SYM-1:0]       msg,
    output logic                   busy,
    output logic                   finishFlag,
    output logic [P*SYM-1:0]       parity,
    output logic [(K+P)*SYM-1:0]   codeword
);

    state_t           state;
    state_t           state_next;
    logic             start_d;
    logic             accept;
    logic [K*SYM-1:0] shift_reg;
    logic [K*SYM-1:0] msg_hold;
    logic [SYM-1:0]   r1;
    logic [SYM-1:0]   r0;
    logic [2:0]       idx;
    logic [SYM-1:0]   fb;
    logic [SYM-1:0]   fb_g1;
    logic [SYM-1:0]   fb_g0;

    assign accept = (state == IDLE) && start && !start_d;
    assign fb     = shift_reg[K*SYM-1 -: SYM] ^ r1;
    assign busy   = (state != IDLE);

    gf64_mul u_mul_g1 (
        .a (fb),
        .b (G1),
        .y (fb_g1)
    );

    gf64_mul u_mul_g0 (
        .a (fb),
        .b (G0),
        .y (fb_g0)
    );

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: one accepted start runs K shift steps then a single finish cycle
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = accept ? SHIFT : IDLE;
            SHIFT:   state_next = (idx == 3'(K-1)) ? FINISH : SHIFT;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: message latch, LFSR division by g(x), and result registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            start_d    <= 1'b0;
            shift_reg  <= '0;
            msg_hold   <= '0;
            r1         <= '0;
            r0         <= '0;
            idx        <= '0;
            finishFlag <= 1'b0;
            parity     <= '0;
            codeword   <= '0;
        end else begin
            start_d <= start;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg  <= msg;
                        msg_hold   <= msg;
                        r1         <= '0;
                        r0         <= '0;
                        idx        <= '0;
                        finishFlag <= 1'b0;
                    end
                end
                SHIFT: begin
                    r1        <= r0 ^ fb_g1;
                    r0        <= fb_g0;
                    shift_reg <= {shift_reg[K*SYM-SYM-1:0], {SYM{1'b0}}};
                    idx       <= idx + 3'd1;
                end
                FINISH: begin
                    parity     <= {r1, r0};
                    codeword   <= {msg_hold, r1, r0};
                    finishFlag <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_parity_encoder.sv
// tb/tb_rs_parity_encoder.sv - self-checking bench for rs_parity_encoder
module tb_rs_parity_encoder;

    logic        clk;
    logic        resetN;
    logic        start;
    logic [41:0] msg;
    logic        busy;
    logic        finishFlag;
    logic [11:0] parity;
    logic [53:0] codeword;

    int errors = 0;
    int checks = 0;

    int exp_t [0:62];
    int log_t [0:63];

    rs_parity_encoder dut (
        .clk        (clk),
        .resetN     (resetN),
        .start      (start),
        .msg        (msg),
        .busy       (busy),
        .finishFlag (finishFlag),
        .parity     (parity),
        .codeword   (codeword)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power table of alpha = x in GF(2^6) modulo x^6+x+1
    task automatic build_tables();
        int v;
        v = 1;
        for (int i = 0; i < 63; i++) begin
            exp_t[i] = v;
            log_t[v] = i;
            v = v << 1;
            if (v & 64) v = v ^ 'h43;
        end
    endtask

    function automatic logic [5:0] gmul(input logic [5:0] a, input logic [5:0] b);
        if (a == 0 || b == 0) return 6'h00;
        return 6'(exp_t[(log_t[a] + log_t[b]) % 63]);
    endfunction

    // Remainder of m(x)*x^2 divided by monic g(x) = x^2 + 6x + 8, by long division
    function automatic logic [11:0] ref_parity(input logic [41:0] m);
        logic [5:0] c [0:8];
        logic [5:0] q;
        for (int i = 0; i < 9; i++) c[i] = 6'h00;
        for (int i = 0; i < 7; i++) c[i+2] = m[i*6 +: 6];
        for (int d = 8; d >= 2; d--) begin
            q = c[d];
            c[d]   = 6'h00;
            c[d-1] = c[d-1] ^ gmul(q, 6'h06);
            c[d-2] = c[d-2] ^ gmul(q, 6'h08);
        end
        return {c[1], c[0]};
    endfunction

    // Horner evaluation of the 9-symbol codeword polynomial at x
    function automatic logic [5:0] eval_cw(input logic [53:0] cw, input logic [5:0] x);
        logic [5:0] acc;
        acc = 6'h00;
        for (int i = 8; i >= 0; i--) acc = gmul(acc, x) ^ cw[i*6 +: 6];
        return acc;
    endfunction

    // Drive one encode request; report busy/finishFlag after the acceptance edge and the latency
    task automatic run_encode(input logic [41:0] m, output logic busy_e0, output logic flag_e0,
                              output int lat);
        @(negedge clk);
        msg   = m;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        busy_e0 = busy;
        flag_e0 = finishFlag;
        start   = 1'b0;
        lat     = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (finishFlag) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        start  = 1'b0;
        msg    = 42'h3ff_ffff_ffff;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, finishFlag, parity, codeword} !== 68'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b flag=%b parity=%h cw=%h required all 0",
                     busy, finishFlag, parity, codeword);
        end
        resetN = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b required 0", busy);
        end
    endtask

    task automatic test_known_vectors();
        logic [41:0] vm [3];
        logic [11:0] vp [3];
        logic b0, f0;
        int lat;
        vm[0] = 42'h0;  vp[0] = 12'h000;
        vm[1] = 42'h1;  vp[1] = {6'h06, 6'h08};
        vm[2] = 42'h40; vp[2] = {6'h1C, 6'h30};
        for (int i = 0; i < 3; i++) begin
            run_encode(vm[i], b0, f0, lat);
            checks++;
            if (b0 !== 1'b1 || f0 !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_accept: busy=%b flag=%b required busy=1 flag=0", i, b0, f0);
            end
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d required 8", i, lat);
            end
            checks++;
            if (parity !== vp[i] || codeword !== {vm[i], vp[i]} || busy !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_result: parity=%h cw=%h busy=%b required parity=%h cw=%h busy=0",
                         i, parity, codeword, busy, vp[i], {vm[i], vp[i]});
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] t;
        logic [41:0] m;
        logic [11:0] ep;
        logic b0, f0;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            t  = {$urandom(), $urandom()};
            m  = t[41:0];
            ep = ref_parity(m);
            run_encode(m, b0, f0, lat);
            checks++;
            if (lat !== 8 || parity !== ep || codeword !== {m, ep}) begin
                errors++;
                $display("FAIL rand_result: msg=%h lat=%0d parity=%h cw=%h required lat=8 parity=%h",
                         m, lat, parity, codeword, ep);
            end
            checks++;
            if (eval_cw(codeword, 6'h02) !== 6'h00 || eval_cw(codeword, 6'h04) !== 6'h00) begin
                errors++;
                $display("FAIL rand_syndrome: cw=%h s1=%h s2=%h required 0 0", codeword,
                         eval_cw(codeword, 6'h02), eval_cw(codeword, 6'h04));
            end
        end
    endtask

    task automatic test_ignore_restart();
        logic [41:0] ma, mb;
        logic [11:0] ep;
        int lat;
        ma = 42'h2A5_1234_5678;
        mb = 42'h15A_8765_4321;
        ep = ref_parity(ma);
        @(negedge clk);
        msg   = ma;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 2) begin
                start = 1'b1;
                msg   = mb;
            end
            if (c == 4) start = 1'b0;
            if (finishFlag) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (lat !== 8 || parity !== ep || codeword !== {ma, ep}) begin
            errors++;
            $display("FAIL ignore_restart: lat=%0d parity=%h cw=%h required lat=8 parity=%h cw=%h",
                     lat, parity, codeword, ep, {ma, ep});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_not_queued: busy=%b required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [41:0] ma, mb;
        logic [11:0] pa, pb;
        logic b0, f0;
        int lat;
        ma = 42'h0AB_CDEF_0123;
        mb = 42'h301_0203_0405;
        pa = ref_parity(ma);
        pb = ref_parity(mb);
        run_encode(ma, b0, f0, lat);
        checks++;
        if (lat !== 8 || parity !== pa) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d parity=%h required lat=8 parity=%h", lat, parity, pa);
        end
        msg   = mb;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || finishFlag !== 1'b0 || parity !== pa || codeword !== {ma, pa}) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b flag=%b parity=%h required busy=1 flag=0 parity=%h",
                     busy, finishFlag, parity, pa);
        end
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (finishFlag) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (lat !== 8 || parity !== pb || codeword !== {mb, pb}) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d parity=%h required lat=8 parity=%h", lat, parity, pb);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || finishFlag !== 1'b1) begin
            errors++;
            $display("FAIL hold_no_retrigger: busy=%b flag=%b required busy=0 flag=1", busy, finishFlag);
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [41:0] m;
        logic [11:0] ep;
        logic b0, f0;
        int lat;
        @(negedge clk);
        msg   = 42'h1F0_F0F0_F0F1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        resetN = 1'b0;
        #1;
        checks++;
        if ({busy, finishFlag, parity, codeword} !== 68'h0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b flag=%b parity=%h cw=%h required all 0",
                     busy, finishFlag, parity, codeword);
        end
        @(negedge clk);
        resetN = 1'b1;
        m  = 42'h12D_3C4B_5A69;
        ep = ref_parity(m);
        run_encode(m, b0, f0, lat);
        checks++;
        if (b0 !== 1'b1 || lat !== 8 || parity !== ep || codeword !== {m, ep}) begin
            errors++;
            $display("FAIL after_reset: busy_e0=%b lat=%0d parity=%h required busy_e0=1 lat=8 parity=%h",
                     b0, lat, parity, ep);
        end
    endtask

    initial begin
        build_tables();
        test_reset();
        test_known_vectors();
        test_random();
        test_ignore_restart();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
